// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data-memory port. Takes one load/store request at a
//   time from the core, drives the word-addressed memory strobes and returns a
//   single-cycle response. Sub-word stores (SB/SH) are done as a
//   read-modify-write of the addressed 32-bit word. Misaligned accesses and
//   illegal funct3 encodings are answered with resp_err and never touch memory.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_store         1 = store, 0 = load
//   req_funct3        RV32 width/sign code
//   req_addr          byte address
//   req_wdata         store data
//   resp_valid        one-cycle completion pulse
//   resp_err          misaligned / illegal request (with resp_valid)
//   resp_rdata        extended load data (0 for stores and errors)
//   MemRead/MemWrite  memory strobes, never high together
//   mem_addr          word-aligned byte address to memory
//   mem_wdata         full word written on MemWrite
//   mem_rdata         combinational read data from memory
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_RD = 3'd1,
    S_ST_RD = 3'd2,
    S_ST_WR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lane;
  logic [15:0]       r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              w_legal;
  logic              w_accept;

  // Width/sign decode of a load: pick the addressed byte or half, then extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte (SB) or half (SH) of the fetched word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    if (f3 == 3'b000) begin
      case (lane)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      res[31:16] = wd;
    end else begin
      res[15:0] = wd;
    end
    return res;
  endfunction

  // Encoding legality plus natural alignment for halves and words.
  function automatic logic is_legal(input logic       st,
                                    input logic [2:0] f3,
                                    input logic [1:0] lo);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~lo[0];
      3'b010:  ok = (lo == 2'b00);
      3'b100:  ok = ~st;
      3'b101:  ok = ~st & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_legal  = is_legal(req_store, req_funct3, req_addr[1:0]);
  assign w_accept = req_valid && (r_state == S_IDLE);

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign MemRead    = r_mem_read;
  assign MemWrite   = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          if (w_accept) begin
            r_funct3 <= req_funct3;
            r_lane   <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            if (!w_legal) begin
              // Rejected requests answer next cycle without any strobe.
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (!req_store) begin
                r_state    <= S_LD_RD;
                r_mem_read <= 1'b1;
              end else if (req_funct3 == 3'b010) begin
                r_state     <= S_ST_WR;
                r_mem_write <= 1'b1;
                r_mem_wdata <= req_wdata;
              end else begin
                r_state    <= S_ST_RD;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        S_LD_RD: begin
          r_mem_read   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= load_extend(mem_rdata, r_funct3, r_lane);
          r_state      <= S_RESP;
        end
        S_ST_RD: begin
          // Fetched word is merged and written on the very next cycle.
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
          r_mem_wdata <= store_merge(mem_rdata, r_wdata, r_funct3, r_lane);
          r_state     <= S_ST_WR;
        end
        S_ST_WR: begin
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:127];
  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) if (MemWrite) mem[mem_addr[8:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [8:0]  addr;
    logic [31:0] wword;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          last_acc = 0;
  logic [31:0] last_rdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic m_legal(input logic st, input logic [2:0] f3, input logic [8:0] a);
    logic sz_ok, al_ok;
    if (st) sz_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    sz_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (f3[1:0] == 2'd1)      al_ok = (a[0] == 1'b0);
    else if (f3[1:0] == 2'd2) al_ok = (a[1:0] == 2'd0);
    else                      al_ok = 1'b1;
    return sz_ok && al_ok;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [8:0] a);
    logic [31:0] sb, shh;
    logic [31:0] b, h;
    sb  = w >> (8 * a[1:0]);
    shh = w >> (16 * a[1]);
    b   = sb & 32'h0000_00FF;
    h   = shh & 32'h0000_FFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [8:0] a);
    int          sh;
    logic [31:0] mask;
    sh   = (f3 == 3'd0) ? 8 * a[1:0] : 16 * a[1];
    mask = ((f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic issue(input logic st, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd, input logic hold);
    exp_t        e;
    logic [31:0] w;
    int          t;
    w       = mem[a[8:2]];
    e.addr  = a;
    e.err   = 1'b0;
    e.rdata = 32'd0;
    e.wword = 32'd0;
    e.nrd   = 0;
    e.nwr   = 0;
    e.lat   = 2;
    if (!m_legal(st, f3, a)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!st) begin
      e.rdata = m_load(w, f3, a);
      e.nrd   = 1;
    end else if (f3 == 3'd2) begin
      e.wword = wd;
      e.nwr   = 1;
    end else begin
      e.wword = m_merge(w, wd, f3, a);
      e.nrd   = 1;
      e.nwr   = 1;
      e.lat   = 3;
    end
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc    = cyc;
    last_acc = cyc;
    q.push_back(e);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: strobes and responses sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (MemRead || MemWrite) begin
        chk("strobe_excl", 32'(MemRead & MemWrite), 32'd0);
        if (q.size() == 0) begin
          chk("spurious_strobe", 32'd1, 32'd0);
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'({q[0].addr[8:2], 2'b00}));
          if (MemWrite) chk("mem_wdata", mem_wdata, q[0].wword);
        end
        n_rd = n_rd + int'(MemRead);
        n_wr = n_wr + int'(MemWrite);
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("n_memread", 32'(n_rd), 32'(e.nrd));
          chk("n_memwrite", 32'(n_wr), 32'(e.nwr));
          last_rdata = resp_rdata;
        end
        n_rd = 0;
        n_wr = 0;
      end
    end
  end

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({pfx, "_resp_err"},   32'(resp_err),   32'd0);
    chk({pfx, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({pfx, "_memread"},    32'(MemRead),    32'd0);
    chk({pfx, "_memwrite"},   32'(MemWrite),   32'd0);
    chk({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({pfx, "_mem_wdata"},  mem_wdata,       32'd0);
  endtask

  localparam logic [2:0] F3_TAB [0:6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

  initial begin
    int          a1, a2, a3;
    logic [31:0] saved;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[4] = 32'h8000_80F0;
    mem[8] = 32'h0000_0000;

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = '0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Sub-word loads
    issue(1'b0, 3'd0, 9'h010, 32'd0, 1'b0); wait_idle();
    chk("lb_const", last_rdata, 32'hFFFF_FFF0);
    issue(1'b0, 3'd4, 9'h010, 32'd0, 1'b0); wait_idle();
    chk("lbu_const", last_rdata, 32'h0000_00F0);
    issue(1'b0, 3'd1, 9'h012, 32'd0, 1'b0); wait_idle();
    chk("lh_const", last_rdata, 32'hFFFF_8000);
    issue(1'b0, 3'd5, 9'h012, 32'd0, 1'b0); wait_idle();
    chk("lhu_const", last_rdata, 32'h0000_8000);
    issue(1'b0, 3'd2, 9'h010, 32'd0, 1'b0); wait_idle();
    chk("lw_const", last_rdata, 32'h8000_80F0);

    // Stores: SW, then read-modify-write SB and SH
    issue(1'b1, 3'd2, 9'h020, 32'hDEAD_BEEF, 1'b0); wait_idle();
    chk("sw_mem", mem[8], 32'hDEAD_BEEF);
    issue(1'b1, 3'd0, 9'h021, 32'h0000_0055, 1'b0); wait_idle();
    chk("sb_mem", mem[8], 32'hDEAD_55EF);
    issue(1'b1, 3'd1, 9'h022, 32'hAAAA_1234, 1'b0); wait_idle();
    chk("sh_mem", mem[8], 32'h1234_55EF);
    issue(1'b0, 3'd0, 9'h023, 32'd0, 1'b0); wait_idle();
    chk("lb_hi_const", last_rdata, 32'h0000_0012);

    // Misaligned and illegal requests
    issue(1'b0, 3'd2, 9'h022, 32'd0, 1'b0); wait_idle();
    issue(1'b1, 3'd1, 9'h023, 32'hFFFF_FFFF, 1'b0); wait_idle();
    chk("sh_err_mem", mem[8], 32'h1234_55EF);
    issue(1'b0, 3'd3, 9'h020, 32'd0, 1'b0); wait_idle();
    issue(1'b1, 3'd4, 9'h020, 32'd0, 1'b0); wait_idle();
    issue(1'b0, 3'd5, 9'h011, 32'd0, 1'b0); wait_idle();

    // Back-to-back loads with req_valid held
    issue(1'b0, 3'd0, 9'h013, 32'd0, 1'b1); a1 = last_acc;
    issue(1'b0, 3'd5, 9'h010, 32'd0, 1'b1); a2 = last_acc;
    issue(1'b0, 3'd2, 9'h020, 32'd0, 1'b0); a3 = last_acc;
    wait_idle();
    chk("b2b_gap1", 32'(a2 - a1), 32'd3);
    chk("b2b_gap2", 32'(a3 - a2), 32'd3);

    // Random mix over the low words
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), F3_TAB[$urandom_range(0, 6)],
            9'($urandom_range(0, 31)), $urandom, 1'b0);
      wait_idle();
    end

    // Reset during an SB read phase aborts the write
    saved = mem[8];
    issue(1'b1, 3'd0, 9'h021, 32'h0000_0099, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    q.delete();
    n_rd = 0;
    n_wr = 0;
    chk_reset_outputs("abort");
    @(negedge clk);
    chk("abort_memwrite2", 32'(MemWrite), 32'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_mem", mem[8], saved);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    issue(1'b1, 3'd0, 9'h020, 32'h0000_0077, 1'b0); wait_idle();
    chk("post_rst_sb", mem[8], {saved[31:8], 8'h77});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule
